// File: rtl/amb_islenen_hazirlayici_pkg.sv
// Shared definitions for the execute-stage operand preparer: forwarding select codes,
// skid-buffer state codes and comparison flag bit positions.
package amb_islenen_hazirlayici_pkg;

    localparam logic [1:0] ILERI_YAZMAC  = 2'b00;
    localparam logic [1:0] ILERI_BELLEK  = 2'b01;
    localparam logic [1:0] ILERI_GERIYAZ = 2'b10;

    typedef enum logic [1:0] {
        BOS   = 2'b00,
        DOLU  = 2'b01,
        TASMA = 2'b10
    } durum_t;

    localparam int unsigned LT_BIT  = 0;
    localparam int unsigned LTU_BIT = 1;
    localparam int unsigned EQ_BIT  = 2;

endpackage

// File: rtl/islenen_karsilastirici.sv
// Combinational signed/unsigned/equal comparator producing the 3-bit lt_ltu flags.
// Shared with the branch unit.
module islenen_karsilastirici
    import amb_islenen_hazirlayici_pkg::*;
#(
    parameter int unsigned GENISLIK = 32
) (
    input  logic [GENISLIK-1:0] a_i,
    input  logic [GENISLIK-1:0] b_i,
    output logic [2:0]          bayrak_o
);

    always_comb begin
        bayrak_o          = 3'b000;
        bayrak_o[LT_BIT]  = $signed(a_i) < $signed(b_i);
        bayrak_o[LTU_BIT] = a_i < b_i;
        bayrak_o[EQ_BIT]  = a_i == b_i;
    end

endmodule

// File: rtl/amb_islenen_hazirlayici.sv
// ALU input bundle preparer: operand select, flag compare, 2-entry skid buffer.
// Forwarding muxes are enabled by defining AMB_ISLENEN_ILETIM_EN.
module amb_islenen_hazirlayici
    import amb_islenen_hazirlayici_pkg::*;
#(
    parameter int unsigned VERI_GENISLIK    = 32,
    parameter int unsigned KONTROL_GENISLIK = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        gecerli_i,
    output logic                        hazir_o,
    input  logic [KONTROL_GENISLIK-1:0] kontrol_i,
    input  logic [VERI_GENISLIK-1:0]    rs1_deger_i,
    input  logic [VERI_GENISLIK-1:0]    rs2_deger_i,
    input  logic [VERI_GENISLIK-1:0]    anlik_i,
    input  logic [VERI_GENISLIK-1:0]    ps_i,
    input  logic                        deger1_sec_i,
    input  logic                        deger2_sec_i,
    input  logic [1:0]                  ileri1_sec_i,
    input  logic [1:0]                  ileri2_sec_i,
    input  logic [VERI_GENISLIK-1:0]    bellek_sonuc_i,
    input  logic [VERI_GENISLIK-1:0]    geriyaz_sonuc_i,
    input  logic                        bosalt_i,
    output logic                        gecerli_o,
    input  logic                        hazir_i,
    output logic [KONTROL_GENISLIK-1:0] kontrol_o,
    output logic [VERI_GENISLIK-1:0]    deger1_o,
    output logic [VERI_GENISLIK-1:0]    deger2_o,
    output logic [2:0]                  lt_ltu_o
);

    logic [VERI_GENISLIK-1:0] rs1_ileri, rs2_ileri;
    logic [VERI_GENISLIK-1:0] deger1, deger2;
    logic [2:0]               bayrak;

`ifdef AMB_ISLENEN_ILETIM_EN
    always_comb begin
        case (ileri1_sec_i)
            ILERI_BELLEK:  rs1_ileri = bellek_sonuc_i;
            ILERI_GERIYAZ: rs1_ileri = geriyaz_sonuc_i;
            default:       rs1_ileri = rs1_deger_i;
        endcase
        case (ileri2_sec_i)
            ILERI_BELLEK:  rs2_ileri = bellek_sonuc_i;
            ILERI_GERIYAZ: rs2_ileri = geriyaz_sonuc_i;
            default:       rs2_ileri = rs2_deger_i;
        endcase
    end
`else
    logic unused_ileri;
    assign unused_ileri = ^{ileri1_sec_i, ileri2_sec_i, bellek_sonuc_i, geriyaz_sonuc_i};
    assign rs1_ileri    = rs1_deger_i;
    assign rs2_ileri    = rs2_deger_i;
`endif

    assign deger1 = deger1_sec_i ? ps_i : rs1_ileri;
    assign deger2 = deger2_sec_i ? anlik_i : rs2_ileri;

    islenen_karsilastirici #(
        .GENISLIK (VERI_GENISLIK)
    ) u_karsilastirici (
        .a_i      (deger1),
        .b_i      (deger2),
        .bayrak_o (bayrak)
    );

    durum_t durum_q, durum_d;
    logic   giris, cikis;
    logic   ana_yukle, ana_skidden, skid_yukle;

    logic [KONTROL_GENISLIK-1:0] skid_kontrol_q;
    logic [VERI_GENISLIK-1:0]    skid_d1_q, skid_d2_q;
    logic [2:0]                  skid_bayrak_q;

    assign gecerli_o = (durum_q != BOS);
    assign hazir_o   = (durum_q != TASMA);
    assign giris     = gecerli_i & hazir_o;
    assign cikis     = gecerli_o & hazir_i;

    always_comb begin
        durum_d     = durum_q;
        ana_yukle   = 1'b0;
        ana_skidden = 1'b0;
        skid_yukle  = 1'b0;
        if (bosalt_i) begin
            // Only valids clear; data registers keep their contents.
            durum_d = BOS;
        end else begin
            unique case (durum_q)
                BOS: begin
                    if (giris) begin
                        durum_d   = DOLU;
                        ana_yukle = 1'b1;
                    end
                end
                DOLU: begin
                    if (giris && cikis) begin
                        ana_yukle = 1'b1;
                    end else if (giris) begin
                        durum_d    = TASMA;
                        skid_yukle = 1'b1;
                    end else if (cikis) begin
                        durum_d = BOS;
                    end
                end
                TASMA: begin
                    if (cikis) begin
                        durum_d     = DOLU;
                        ana_skidden = 1'b1;
                    end
                end
                default: durum_d = BOS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q        <= BOS;
            kontrol_o      <= '0;
            deger1_o       <= '0;
            deger2_o       <= '0;
            lt_ltu_o       <= '0;
            skid_kontrol_q <= '0;
            skid_d1_q      <= '0;
            skid_d2_q      <= '0;
            skid_bayrak_q  <= '0;
        end else begin
            durum_q <= durum_d;
            if (ana_yukle) begin
                kontrol_o <= kontrol_i;
                deger1_o  <= deger1;
                deger2_o  <= deger2;
                lt_ltu_o  <= bayrak;
            end else if (ana_skidden) begin
                kontrol_o <= skid_kontrol_q;
                deger1_o  <= skid_d1_q;
                deger2_o  <= skid_d2_q;
                lt_ltu_o  <= skid_bayrak_q;
            end
            if (skid_yukle) begin
                skid_kontrol_q <= kontrol_i;
                skid_d1_q      <= deger1;
                skid_d2_q      <= deger2;
                skid_bayrak_q  <= bayrak;
            end
        end
    end

endmodule

// File: doc/amb_islenen_hazirlayici.md
Name: amb_islenen_hazirlayici

Overview:
- Execute-stage front end that produces the ALU input bundle: control code, two operands and comparison flags.
- Sits between decode and the ALU. Selects operands (register, immediate, PC, forwarded result) and computes signed, unsigned and equal flags on the selected operands.
- Registers the bundle behind a 2-entry skid buffer with a valid/ready handshake, so decode never sees a combinational ready path from the ALU side.

Parameters:
- VERI_GENISLIK, 32, operand and result width in bits.
- KONTROL_GENISLIK, 4, ALU control code width in bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- gecerli_i  input  1  decode offers an instruction
- hazir_o  output  1  block can accept this cycle
- kontrol_i  input  KONTROL_GENISLIK  ALU control code from decode
- rs1_deger_i  input  VERI_GENISLIK  register file rs1 value
- rs2_deger_i  input  VERI_GENISLIK  register file rs2 value
- anlik_i  input  VERI_GENISLIK  sign-extended immediate
- ps_i  input  VERI_GENISLIK  instruction PC
- deger1_sec_i  input  1  0: rs1 path, 1: PC
- deger2_sec_i  input  1  0: rs2 path, 1: immediate
- ileri1_sec_i  input  2  rs1 source: 00 register file, 01 memory-stage result, 10 writeback result, 11 reserved (register file)
- ileri2_sec_i  input  2  rs2 source, same encoding as ileri1_sec_i
- bellek_sonuc_i  input  VERI_GENISLIK  forwarded memory-stage result
- geriyaz_sonuc_i  input  VERI_GENISLIK  forwarded writeback result
- bosalt_i  input  1  flush (branch mispredict / exception)
- gecerli_o  output  1  bundle valid toward ALU
- hazir_i  input  1  ALU stage accepts the bundle
- kontrol_o  output  KONTROL_GENISLIK  registered control code
- deger1_o  output  VERI_GENISLIK  registered operand 1
- deger2_o  output  VERI_GENISLIK  registered operand 2
- lt_ltu_o  output  3  bit0 signed less-than, bit1 unsigned less-than, bit2 equal, all of deger1 vs deger2

Behaviour:
- Reset (rst_ni low, asynchronous):
  - gecerli_o=0, hazir_o=1.
  - kontrol_o, deger1_o, deger2_o, lt_ltu_o all 0.
  - Both buffer entries invalid; state BOS.
- Operand select (combinational, on the input side):
  - Forwarded rs1/rs2 come from ileri*_sec_i.
  - deger1 is PC if deger1_sec_i, else forwarded rs1.
  - deger2 is immediate if deger2_sec_i, else forwarded rs2.
- Flags: computed on the selected deger1/deger2 and registered together with them. lt_ltu_o always matches deger1_o/deger2_o.
- Handshakes:
  - Input transfer occurs when gecerli_i & hazir_o.
  - Output transfer occurs when gecerli_o & hazir_i.
  - hazir_o is a registered signal: 1 exactly when the skid entry is empty.
- Latency: 1 cycle from input transfer to gecerli_o when the buffer was empty.
- States: BOS (no entries), DOLU (main entry only), TASMA (main + skid entries). Transitions:
  - BOS: input transfer -> DOLU, bundle loaded into main.
  - DOLU:
    - input and output transfer together -> DOLU, main reloaded with the new bundle.
    - input transfer only -> TASMA, new bundle goes to skid.
    - output transfer only -> BOS.
  - TASMA: hazir_o=0. Output transfer -> DOLU, skid moves into main, skid cleared.
- Ordering: strict FIFO order; no bundle is duplicated or dropped.
- Flush (bosalt_i=1):
  - Next edge: both entries invalid, state BOS, hazir_o=1.
  - A same-cycle input transfer is discarded.
  - Flush takes priority over every transition.
  - Data registers keep their contents; only valids clear.
- Stability: while gecerli_o=1 & hazir_i=0, all outputs hold stable.
- Arithmetic: no width growth; comparison is on full VERI_GENISLIK. Equal operands give lt_ltu_o=3'b100.
- Reset mid-operation: asynchronous clear to the reset values above; no pending bundle survives.

Optional Feature:
- Macro: AMB_ISLENEN_ILETIM_EN.
- Defined: forwarding muxes are active as described above.
- Undefined:
  - ileri1_sec_i, ileri2_sec_i, bellek_sonuc_i and geriyaz_sonuc_i are ignored.
  - rs1/rs2 always come from the register file.
  - Ports remain present so integration is unchanged.

Decomposition:
- Shared package/header (tanimlamalar.vh):
  - ileri*_sec encodings as `ILERI_YAZMAC, `ILERI_BELLEK, `ILERI_GERIYAZ.
  - State codes BOS/DOLU/TASMA.
  - lt_ltu bit indices.
- One natural sub-module: islenen_karsilastirici, the combinational signed/unsigned/equal comparator producing the 3-bit flags. Reusable by the branch unit.

Test Plan:
- rs1=0xFFFFFFFF, rs2=0x00000001, sel=00/00 -> one cycle later deger1_o=0xFFFFFFFF, deger2_o=1, lt_ltu_o=3'b001.
- deger2_sec_i=1, anlik_i=0x00000005, rs1=0x00000005 -> lt_ltu_o=3'b100.
- ileri1_sec_i=01, bellek_sonuc_i=0x12345678 -> deger1_o=0x12345678 with macro. Without macro -> deger1_o=rs1_deger_i.
- hazir_i=0, three back-to-back offers A,B,C -> A in main, B in skid, hazir_o=0, C held at input. Release hazir_i -> outputs A,B,C in order, no loss.
- TASMA state, bosalt_i=1 with gecerli_i=1 -> next cycle gecerli_o=0, hazir_o=1, offered bundle not emitted.
- Assert rst_ni=0 while in DOLU -> gecerli_o=0 immediately (asynchronous), all data outputs 0.
